// File: rtl/draw_wr_combiner_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : draw_wr_combiner_pkg
// Description : Shared types, constants and helpers for the draw write
//               combiner (merge-line record, output FSM states, nibble mask
//               expansion).
// Revision    : 1.0 - initial release
// ============================================================================
package draw_wr_combiner_pkg;

    // Default number of idle cycles before a partial merge line is pushed out
    localparam int DRAW_WRC_TIMEOUT = 8;

    // One pending VRAM write: word address, data and per-nibble write mask
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  mask;
    } vram_wr_line_t;

    // Output register state: empty, or holding a write until the arbiter acks
    typedef enum logic [0:0] {
        OUT_IDLE = 1'b0,
        OUT_WAIT = 1'b1
    } out_state_t;

    // Expand a 4-bit nibble mask to a 16-bit bit mask (bit3 -> [15:12])
    function automatic logic [15:0] nibble_expand(input logic [3:0] mask);
        logic [15:0] expanded;
        expanded = '0;
        for (int i = 0; i < 4; i++) begin
            expanded[i*4 +: 4] = {4{mask[i]}};
        end
        return expanded;
    endfunction

endpackage : draw_wr_combiner_pkg
`default_nettype wire

// File: rtl/draw_wr_combiner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : draw_wr_combiner
// Description : Merges consecutive draw-unit nibble writes to the same VRAM
//               word into one masked write. Holds a single merge line and a
//               single output register; back-pressures upstream by
//               withholding the accept pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_wr_combiner
    import draw_wr_combiner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DRAW_WRC_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n_i,
    // upstream (draw unit) write port
    input  logic        in_sel_i,
    input  logic        in_wr_i,
    input  logic [3:0]  in_mask_i,
    input  logic [15:0] in_addr_i,
    input  logic [15:0] in_data_i,
    output logic        in_ack_o,
    // force the merge line out
    input  logic        flush_i,
    // downstream (VRAM arbiter) write port
    input  logic        vram_ack_i,
    output logic        vram_sel_o,
    output logic        vram_wr_o,
    output logic [3:0]  vram_mask_o,
    output logic [15:0] vram_addr_o,
    output logic [15:0] vram_data_o,
    output logic        busy_o
);

    // Idle counter compare value; legal range is 1..255 so 8 bits suffice
    localparam logic [7:0] TIMEOUT_C = TIMEOUT_CYCLES[7:0];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic          ack_q,        ack_d;
    logic          line_valid_q, line_valid_d;
    vram_wr_line_t line_q,       line_d;
    logic [7:0]    idle_cnt_q,   idle_cnt_d;

    out_state_t    state_q;
    logic          vram_sel_q;
    logic          vram_wr_q;
    vram_wr_line_t out_q;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic        req;
    logic        addr_hit;
    logic        out_free;
    logic        accept;
    logic        merge;
    logic        load;
    logic        conflict;
    logic        line_full;
    logic        timed_out;
    logic        flush_req;
    logic        handoff;
    logic [15:0] in_bitmask;

    // The ack cycle belongs to the request just accepted, so it is masked here
    assign req        = in_sel_i & ~ack_q;
    assign addr_hit   = line_valid_q & (in_addr_i == line_q.addr);
    // Output can take a new line if empty or being acked this very cycle
    assign out_free   = (state_q == OUT_IDLE) | vram_ack_i;
    // Reads, merges and loads into an empty line never stall; a different
    // address only goes through when the current line can move out now
    assign accept     = req & (~in_wr_i | ~line_valid_q | addr_hit | out_free);
    assign merge      = accept & in_wr_i & addr_hit;
    assign load       = accept & in_wr_i & ~addr_hit;
    assign conflict   = load & line_valid_q;

    assign line_full  = (line_q.mask == 4'b1111);
    assign timed_out  = (idle_cnt_q == TIMEOUT_C);
    // A merge in this cycle takes precedence; the full check then happens on
    // the following cycle with the merged mask
    assign flush_req  = line_valid_q & ~merge & (line_full | timed_out | flush_i);
    assign handoff    = out_free & (conflict | flush_req);

    assign in_bitmask = nibble_expand(in_mask_i);

    // Next-state for the merge line, accept pulse and idle counter
    always_comb begin
        ack_d        = accept;
        line_d       = line_q;
        line_valid_d = line_valid_q;

        if (merge) begin
            line_d.data = (line_q.data & ~in_bitmask) | (in_data_i & in_bitmask);
            line_d.mask = line_q.mask | in_mask_i;
        end else if (load) begin
            line_d.addr  = in_addr_i;
            line_d.data  = in_data_i & in_bitmask;
            line_d.mask  = in_mask_i;
            line_valid_d = 1'b1;
        end else if (handoff) begin
            line_valid_d = 1'b0;
        end

        if (accept || !line_valid_q) begin
            idle_cnt_d = 8'd0;
        end else if (timed_out) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
        end
    end

    // Merge line, accept pulse and idle counter registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ack_q        <= 1'b0;
            line_valid_q <= 1'b0;
            line_q       <= '0;
            idle_cnt_q   <= 8'd0;
        end else begin
            ack_q        <= ack_d;
            line_valid_q <= line_valid_d;
            line_q       <= line_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    // Output FSM: captures the line on handoff and holds it until acked
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= OUT_IDLE;
            vram_sel_q <= 1'b0;
            vram_wr_q  <= 1'b0;
            out_q      <= '0;
        end else begin
            case (state_q)
                OUT_IDLE: begin
                    if (handoff) begin
                        state_q    <= OUT_WAIT;
                        vram_sel_q <= 1'b1;
                        vram_wr_q  <= 1'b1;
                        out_q      <= line_q;
                    end
                end
                OUT_WAIT: begin
                    // Handoff here implies vram_ack_i, so the next write
                    // follows back-to-back with sel held high
                    if (handoff) begin
                        out_q <= line_q;
                    end else if (vram_ack_i) begin
                        state_q    <= OUT_IDLE;
                        vram_sel_q <= 1'b0;
                        vram_wr_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= OUT_IDLE;
                    vram_sel_q <= 1'b0;
                    vram_wr_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ack_o    = ack_q;
    assign vram_sel_o  = vram_sel_q;
    assign vram_wr_o   = vram_wr_q;
    assign vram_addr_o = out_q.addr;
    assign vram_data_o = out_q.data;
    assign vram_mask_o = out_q.mask;
    assign busy_o      = line_valid_q | (state_q == OUT_WAIT) | ack_q;

endmodule : draw_wr_combiner
`default_nettype wire

// File: tb/tb_draw_wr_combiner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_draw_wr_combiner
// Description : Self-checking bench for draw_wr_combiner: directed timing
//               scenarios plus a randomized run checked against a VRAM image
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_wr_combiner;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        in_sel_i, in_wr_i, flush_i, vram_ack_i;
    logic [3:0]  in_mask_i;
    logic [15:0] in_addr_i, in_data_i;
    logic        in_ack_o, vram_sel_o, vram_wr_o, busy_o;
    logic [3:0]  vram_mask_o;
    logic [15:0] vram_addr_o, vram_data_o;

    draw_wr_combiner #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .in_sel_i    (in_sel_i),
        .in_wr_i     (in_wr_i),
        .in_mask_i   (in_mask_i),
        .in_addr_i   (in_addr_i),
        .in_data_i   (in_data_i),
        .in_ack_o    (in_ack_o),
        .flush_i     (flush_i),
        .vram_ack_i  (vram_ack_i),
        .vram_sel_o  (vram_sel_o),
        .vram_wr_o   (vram_wr_o),
        .vram_mask_o (vram_mask_o),
        .vram_addr_o (vram_addr_o),
        .vram_data_o (vram_data_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic [3:0]  m;
        int          c;
    } rec_t;

    rec_t wq[$];
    int   ack_mode = 1;   // 0 low, 1 ack immediately, 2 random ack, 3 driven by main
    int   tests = 0;
    int   fails = 0;

    function automatic logic [15:0] expand(input logic [3:0] m);
        return {{4{m[3]}}, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
    endfunction

    function automatic rec_t rq(input int i);
        rec_t r;
        r = '{a: 16'h0, d: 16'h0, m: 4'h0, c: -1};
        if (i < wq.size()) r = wq[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one request and hold it until accepted; acc = accept cycle
    task automatic wr(input logic [15:0] a, input logic [3:0] m, input logic [15:0] d,
                      input logic w, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        in_sel_i = 1'b1; in_wr_i = w; in_addr_i = a; in_mask_i = m; in_data_i = d;
        for (int k = 0; k < 300 && !got; k++) begin
            @(posedge clk);
            #1;
            if (in_ack_o) begin
                got = 1'b1;
                acc = cyc - 1;
            end
        end
        in_sel_i = 1'b0;
        if (!got) chk("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_wq(input int n, input int budget);
        for (int k = 0; k < budget && wq.size() < n; k++) begin
            @(posedge clk);
            #4;
        end
    endtask

    // Arbiter model and VRAM write monitor
    initial begin
        vram_ack_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_mode == 0)      vram_ack_i = 1'b0;
            else if (ack_mode == 1) vram_ack_i = vram_sel_o;
            else if (ack_mode == 2) vram_ack_i = vram_sel_o & ($urandom_range(0, 2) != 0);
            #1;
            if (reset_n_i && vram_sel_o && vram_ack_i)
                wq.push_back('{a: vram_addr_o, d: vram_data_o, m: vram_mask_o, c: cyc});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2, x, stall_acks, n_acc;
        logic [15:0] exp_w [8];
        logic [3:0]  exp_m [8];
        logic [15:0] dut_w [8];
        logic [3:0]  dut_m [8];
        logic [15:0] ra, rd;
        logic [3:0]  rm;
        logic        rw;
        rec_t        r;

        reset_n_i = 1'b0;
        in_sel_i = 1'b0; in_wr_i = 1'b0; in_mask_i = 4'h0;
        in_addr_i = 16'h0; in_data_i = 16'h0; flush_i = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel",  32'(vram_sel_o), 32'd0);
        chk("rst_wr",   32'(vram_wr_o),  32'd0);
        chk("rst_ack",  32'(in_ack_o),   32'd0);
        chk("rst_busy", 32'(busy_o),     32'd0);
        chk("rst_addr", 32'(vram_addr_o), 32'd0);
        chk("rst_mask", 32'(vram_mask_o), 32'd0);
        reset_n_i = 1'b1;
        tick(2);
        chk("idle_busy", 32'(busy_o), 32'd0);

        // ---- 1: four nibbles to one word -> single full write ----
        ack_mode = 1;
        wq.delete();
        wr(16'h0100, 4'b1000, 16'h1111, 1'b1, a);
        wr(16'h0100, 4'b0100, 16'h2222, 1'b1, a);
        wr(16'h0100, 4'b0010, 16'h3333, 1'b1, a);
        wr(16'h0100, 4'b0001, 16'h4444, 1'b1, a);
        wait_wq(1, 20);
        tick(T + 4);
        r = rq(0);
        chk("t1_count", 32'(wq.size()), 32'd1);
        chk("t1_addr",  32'(r.a), 32'h0100);
        chk("t1_mask",  32'(r.m), 32'hF);
        chk("t1_data",  32'(r.d), 32'h1234);
        chk("t1_cycle", 32'(r.c), 32'(a + 2));

        // ---- 2: conflicting address pushes first line; second times out ----
        wq.delete();
        wr(16'h0200, 4'b1100, 16'hABAB, 1'b1, a1);
        wr(16'h0201, 4'b0011, 16'hCDCD, 1'b1, a2);
        chk("t2_ack_pulse", 32'(in_ack_o), 32'd1);
        tick(1);
        chk("t2_ack_single", 32'(in_ack_o), 32'd0);
        wait_wq(2, 40);
        tick(2);
        chk("t2_count", 32'(wq.size()), 32'd2);
        r = rq(0);
        chk("t2_w0_addr", 32'(r.a), 32'h0200);
        chk("t2_w0_mask", 32'(r.m), 32'hC);
        chk("t2_w0_data", 32'(r.d & expand(r.m)), 32'hAB00);
        chk("t2_w0_cyc",  32'(r.c), 32'(a2 + 1));
        r = rq(1);
        chk("t2_w1_addr", 32'(r.a), 32'h0201);
        chk("t2_w1_mask", 32'(r.m), 32'h3);
        chk("t2_w1_data", 32'(r.d & expand(r.m)), 32'h00CD);
        chk("t2_w1_cyc",  32'(r.c), 32'(a2 + T + 2));

        // ---- 3: overlapping nibble, flush arriving with the merge ----
        wq.delete();
        wr(16'h0300, 4'b1000, 16'h1000, 1'b1, a);
        tick(1);
        flush_i = 1'b1;
        wr(16'h0300, 4'b1000, 16'h7000, 1'b1, a);
        wait_wq(1, 20);
        flush_i = 1'b0;
        tick(T + 4);
        r = rq(0);
        chk("t3_count", 32'(wq.size()), 32'd1);
        chk("t3_mask",  32'(r.m), 32'h8);
        chk("t3_nib",   32'(r.d[15:12]), 32'h7);
        chk("t3_cyc",   32'(r.c), 32'(a + 2));
        chk("t3_busy",  32'(busy_o), 32'd0);

        // ---- 4/5: stall behind pending output, zero-bubble handoff ----
        wq.delete();
        ack_mode = 3;
        vram_ack_i = 1'b0;
        wr(16'h0400, 4'b1111, 16'hAAAA, 1'b1, a);
        wr(16'h0401, 4'b0001, 16'h0005, 1'b1, a);
        in_sel_i = 1'b1; in_wr_i = 1'b1; in_addr_i = 16'h0402;
        in_mask_i = 4'b0010; in_data_i = 16'h0060;
        stall_acks = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (in_ack_o) stall_acks++;
        end
        chk("t4_stall_acks", 32'(stall_acks), 32'd0);
        chk("t4_hold_sel",   32'(vram_sel_o), 32'd1);
        chk("t4_hold_addr",  32'(vram_addr_o), 32'h0400);
        vram_ack_i = 1'b1;
        x = cyc;
        @(posedge clk);
        #1;
        vram_ack_i = 1'b0;
        ack_mode = 1;
        in_sel_i = 1'b0;
        chk("t5_in_ack", 32'(in_ack_o), 32'd1);
        chk("t5_sel",    32'(vram_sel_o), 32'd1);
        chk("t5_wr",     32'(vram_wr_o), 32'd1);
        chk("t5_addr",   32'(vram_addr_o), 32'h0401);
        chk("t5_mask",   32'(vram_mask_o), 32'h1);
        chk("t5_data",   32'(vram_data_o & 16'h000F), 32'h5);
        wait_wq(3, 30);
        tick(2);
        chk("t4_count", 32'(wq.size()), 32'd3);
        r = rq(0);
        chk("t4_w0_addr", 32'(r.a), 32'h0400);
        chk("t4_w0_cyc",  32'(r.c), 32'(x));
        r = rq(1);
        chk("t4_w1_addr", 32'(r.a), 32'h0401);
        chk("t4_w1_cyc",  32'(r.c), 32'(x + 1));
        r = rq(2);
        chk("t4_w2_addr", 32'(r.a), 32'h0402);
        chk("t4_w2_data", 32'(r.d & expand(r.m)), 32'h0060);
        chk("t4_w2_cyc",  32'(r.c), 32'(x + T + 2));

        // ---- 6: asynchronous reset mid-transfer ----
        ack_mode = 3;
        vram_ack_i = 1'b0;
        wr(16'h0500, 4'b1111, 16'h5555, 1'b1, a);
        wr(16'h0501, 4'b0010, 16'h00B0, 1'b1, a);
        chk("t6_pre_sel",  32'(vram_sel_o), 32'd1);
        chk("t6_pre_busy", 32'(busy_o), 32'd1);
        reset_n_i = 1'b0;
        #1;
        chk("t6_sel",  32'(vram_sel_o), 32'd0);
        chk("t6_wr",   32'(vram_wr_o),  32'd0);
        chk("t6_ack",  32'(in_ack_o),   32'd0);
        chk("t6_busy", 32'(busy_o),     32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        ack_mode = 1;
        tick(1);
        wq.delete();
        wr(16'h0010, 4'b0110, 16'h0BC0, 1'b1, a);
        wait_wq(1, T + 10);
        tick(T + 4);
        r = rq(0);
        chk("t6_count", 32'(wq.size()), 32'd1);
        chk("t6_addr",  32'(r.a), 32'h0010);
        chk("t6_mask",  32'(r.m), 32'h6);
        chk("t6_data",  32'(r.d & expand(r.m)), 32'h0BC0);
        chk("t6_cyc",   32'(r.c), 32'(a + T + 2));

        // ---- randomized traffic against a VRAM image model ----
        wq.delete();
        ack_mode = 2;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            exp_w[i] = 16'h0; exp_m[i] = 4'h0;
            dut_w[i] = 16'h0; dut_m[i] = 4'h0;
        end
        for (int i = 0; i < 250; i++) begin
            ra = 16'h0800 + 16'($urandom_range(0, 7));
            rm = 4'($urandom_range(1, 15));
            rd = 16'($urandom);
            rw = ($urandom_range(0, 7) != 0);
            flush_i = ($urandom_range(0, 9) == 0);
            wr(ra, rm, rd, rw, a);
            if (rw) begin
                exp_w[ra[2:0]] = (exp_w[ra[2:0]] & ~expand(rm)) | (rd & expand(rm));
                exp_m[ra[2:0]] = exp_m[ra[2:0]] | rm;
                n_acc++;
            end
            if ($urandom_range(0, 3) == 0) tick($urandom_range(0, 12));
        end
        flush_i = 1'b1;
        ack_mode = 1;
        for (int k = 0; k < 100 && busy_o; k++) tick(1);
        flush_i = 1'b0;
        tick(2);
        chk("rnd_drain", 32'(busy_o), 32'd0);
        chk("rnd_fewer", 32'(wq.size() <= n_acc && wq.size() > 0), 32'd1);
        foreach (wq[i]) begin
            if (wq[i].a[15:3] == 13'h0100) begin
                dut_w[wq[i].a[2:0]] = (dut_w[wq[i].a[2:0]] & ~expand(wq[i].m)) |
                                      (wq[i].d & expand(wq[i].m));
                dut_m[wq[i].a[2:0]] = dut_m[wq[i].a[2:0]] | wq[i].m;
            end
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rnd_word%0d", i), 32'(dut_w[i]), 32'(exp_w[i]));
            chk($sformatf("rnd_mask%0d", i), 32'(dut_m[i]), 32'(exp_m[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_draw_wr_combiner
`default_nettype wire
